// File: rtl/aes128_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes128_host_ctrl
// Description : Register-mapped host controller for the aes128_fsm core.
//               Software loads key, data block and operation as 32-bit words,
//               then starts the core. The controller issues a single-cycle
//               start once the core is ready, captures the 128-bit result,
//               raises a done interrupt and aborts a hung operation with a
//               completion watchdog.
// Ports       : clk_i, rst_n_i            - clock, async active-low reset
//               addr_i/wr_en_i/rd_en_i    - word-addressed register bus
//               wdata_i/rdata_o           - write data / registered read data
//               irq_o                     - irq_pending & irq_en
//               core_start_o/core_op_o    - start pulse and operation to core
//               core_key_o/core_data_o    - key and data block to core
//               core_result_i/valid_i     - result and level valid from core
//               core_ready_i              - core waiting for a command
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [3:0]   addr_i,
    input  logic         wr_en_i,
    input  logic         rd_en_i,
    input  logic [31:0]  wdata_i,
    output logic [31:0]  rdata_o,
    output logic         irq_o,
    output logic         core_start_o,
    output logic [1:0]   core_op_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_data_o,
    input  logic [127:0] core_result_i,
    input  logic         core_valid_i,
    input  logic         core_ready_i
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_launch = 2'd1;
    localparam logic [1:0]  c_st_busy   = 2'd2;

    localparam logic [3:0]  c_addr_ctrl = 4'hC;
    localparam logic [3:0]  c_addr_stat = 4'hD;

    localparam logic [15:0] c_timeout   = 16'(TIMEOUT_CYCLES);
    localparam logic        c_wdog_en   = (TIMEOUT_CYCLES != 0);

    logic [1:0]   r_state;
    logic [127:0] r_key;
    logic [127:0] r_data;
    logic [127:0] r_result;
    logic [1:0]   r_core_op;
    logic         r_ctrl_op;
    logic         r_irq_en;
    logic         r_irq_pending;
    logic         r_done;
    logic         r_error;
    logic         r_timeout;
    logic [15:0]  r_wdog;
    logic [31:0]  r_rdata;

    logic         w_idle;
    logic         w_active;
    logic [15:0]  w_wdog_next;
    logic         w_complete;
    logic         w_abort;
    logic         w_launch;
    logic         w_wr_block;
    logic         w_wr_ctrl;
    logic         w_start_req;
    logic         w_reject;
    logic [6:0]   w_word_lsb;
    logic [31:0]  w_status;
    logic [31:0]  w_rd_data;

    assign w_idle      = (r_state == c_st_idle);
    assign w_active    = (r_state == c_st_launch) || (r_state == c_st_busy);
    assign w_wdog_next = r_wdog + 16'd1;

    // Expiry is judged on the incremented count so the block spends exactly
    // TIMEOUT_CYCLES cycles in LAUNCH/BUSY before returning to IDLE.
    assign w_complete  = (r_state == c_st_busy) && core_valid_i;
    assign w_abort     = c_wdog_en && w_active && (w_wdog_next == c_timeout)
                         && !w_complete;
    assign w_launch    = (r_state == c_st_launch) && core_ready_i && !w_abort;

    // Word 0 is the most-significant word: word n lives at bit 32*(3-n).
    assign w_word_lsb  = {~addr_i[1:0], 5'b00000};

    assign w_wr_block  = wr_en_i && !addr_i[3];
    assign w_wr_ctrl   = wr_en_i && (addr_i == c_addr_ctrl);
    assign w_start_req = w_wr_ctrl && wdata_i[0];
    assign w_reject    = !w_idle && (w_wr_block || w_start_req);

    assign w_status    = {26'd0, r_timeout, r_error, r_irq_pending,
                          core_ready_i, r_done, !w_idle};

    always_comb begin
        w_rd_data = 32'd0;
        case (addr_i)
            4'h8, 4'h9, 4'hA, 4'hB: w_rd_data = r_result[w_word_lsb +: 32];
            c_addr_ctrl:            w_rd_data = {29'd0, r_irq_en, r_ctrl_op, 1'b0};
            c_addr_stat:            w_rd_data = w_status;
            default:                w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= c_st_idle;
            r_key         <= 128'd0;
            r_data        <= 128'd0;
            r_result      <= 128'd0;
            r_core_op     <= 2'b00;
            r_ctrl_op     <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irq_pending <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_timeout     <= 1'b0;
            r_wdog        <= 16'd0;
            r_rdata       <= 32'd0;
        end else begin
            // Key/data only change in IDLE, which keeps the core inputs
            // stable for the whole operation.
            if (w_wr_block && w_idle) begin
                if (!addr_i[2]) begin
                    r_key[w_word_lsb +: 32] <= wdata_i;
                end else begin
                    r_data[w_word_lsb +: 32] <= wdata_i;
                end
            end

            // Clears are applied first; any set later in this block for the
            // same cycle overrides them.
            if (w_wr_ctrl) begin
                r_ctrl_op <= wdata_i[1];
                r_irq_en  <= wdata_i[2];
                if (wdata_i[3]) begin
                    r_irq_pending <= 1'b0;
                end
                if (wdata_i[4]) begin
                    r_error <= 1'b0;
                end
            end

            if (w_reject) begin
                r_error <= 1'b1;
            end

            if (rd_en_i) begin
                r_rdata <= w_rd_data;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_start_req) begin
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_wdog    <= 16'd0;
                        r_core_op <= {1'b0, wdata_i[1]};
                        r_state   <= c_st_launch;
                    end
                end
                c_st_launch, c_st_busy: begin
                    r_wdog <= w_wdog_next;
                    if (w_complete) begin
                        r_result      <= core_result_i;
                        r_done        <= 1'b1;
                        r_irq_pending <= 1'b1;
                        r_state       <= c_st_idle;
                    end else if (w_abort) begin
                        r_timeout     <= 1'b1;
                        r_error       <= 1'b1;
                        r_irq_pending <= 1'b1;
                        r_state       <= c_st_idle;
                    end else if (w_launch) begin
                        r_state <= c_st_busy;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // The start pulse follows core_ready_i within the LAUNCH cycle so the
    // core sees it on the very cycle it becomes ready; it also drops as soon
    // as reset forces the state back to IDLE.
    assign core_start_o = w_launch;
    assign core_op_o    = r_core_op;
    assign core_key_o   = r_key;
    assign core_data_o  = r_data;
    assign rdata_o      = r_rdata;
    assign irq_o        = r_irq_pending & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_aes128_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_host_ctrl
// Description : Self-checking bench for aes128_host_ctrl with a stub core
//               that answers the FIPS-197 known-answer vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_host_ctrl;

    localparam int unsigned TO       = 20;
    localparam int          STUB_LAT = 8;
    localparam logic [127:0] c_key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [3:0]   addr_i;
    logic         wr_en_i;
    logic         rd_en_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         irq_o;
    logic         core_start_o;
    logic [1:0]   core_op_o;
    logic [127:0] core_key_o;
    logic [127:0] core_data_o;
    logic [127:0] core_result_i;
    logic         core_valid_i;
    logic         core_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    aes128_host_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .addr_i        (addr_i),
        .wr_en_i       (wr_en_i),
        .rd_en_i       (rd_en_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .irq_o         (irq_o),
        .core_start_o  (core_start_o),
        .core_op_o     (core_op_o),
        .core_key_o    (core_key_o),
        .core_data_o   (core_data_o),
        .core_result_i (core_result_i),
        .core_valid_i  (core_valid_i),
        .core_ready_i  (core_ready_i)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- stub core ----------------
    function automatic logic [127:0] ref_core(input logic [1:0] op, input logic [127:0] k,
                                              input logic [127:0] d);
        if (op == 2'b00 && k == c_key && d == c_pt) return c_ct;
        if (op == 2'b01 && k == c_key && d == c_ct) return c_pt;
        return d ^ k;
    endfunction

    logic         stub_ready, stub_valid, stub_run;
    logic         stub_hang   = 1'b0;
    logic         ready_block = 1'b0;
    logic [127:0] stub_res, stub_calc;
    int           stub_cnt;
    int           n_starts = 0;

    assign core_ready_i  = stub_ready & ~ready_block;
    assign core_valid_i  = stub_valid;
    assign core_result_i = stub_res;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stub_ready <= 1'b1;
            stub_valid <= 1'b0;
            stub_run   <= 1'b0;
            stub_res   <= '0;
            stub_calc  <= '0;
            stub_cnt   <= 0;
        end else if (core_start_o) begin
            stub_valid <= 1'b0;
            if (!stub_hang) begin
                stub_ready <= 1'b0;
                stub_run   <= 1'b1;
                stub_cnt   <= STUB_LAT;
                stub_calc  <= ref_core(core_op_o, core_key_o, core_data_o);
            end
        end else if (stub_run) begin
            if (stub_cnt == 1) begin
                stub_run   <= 1'b0;
                stub_ready <= 1'b1;
                stub_valid <= 1'b1;
                stub_res   <= stub_calc;
            end
            stub_cnt <= stub_cnt - 1;
        end
    end

    always @(posedge clk_i) begin
        if (rst_n_i && core_start_o) n_starts <= n_starts + 1;
    end

    // ---------------- behavioural model ----------------
    logic [127:0] m_key, m_data, m_result;
    logic [1:0]   m_op;
    logic         m_ctrl_op;
    bit           m_busy, m_started, m_done, m_irq, m_irq_en, m_err, m_to;
    int           m_cycles;
    logic [31:0]  m_rdata;

    function automatic bit m_expire_now();
        return m_busy && (TO != 0) && (m_cycles + 1 == int'(TO));
    endfunction

    task automatic model_reset();
        m_key = '0; m_data = '0; m_result = '0; m_op = 2'b00; m_ctrl_op = 1'b0;
        m_busy = 0; m_started = 0; m_done = 0; m_irq = 0; m_irq_en = 0;
        m_err = 0; m_to = 0; m_cycles = 0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit fin_ok, fin_to, go, accept, idle;
        int w;
        logic [31:0] rd;
        idle   = !m_busy;
        fin_ok = m_busy && m_started && core_valid_i;
        fin_to = !fin_ok && m_expire_now();
        go     = m_busy && !m_started && core_ready_i && !fin_to;
        accept = 0;
        w      = int'(addr_i[1:0]);
        if (rd_en_i) begin
            rd = '0;
            if (addr_i >= 4'h8 && addr_i <= 4'hB) rd = m_result[127 - 32*w -: 32];
            else if (addr_i == 4'hC) rd = {29'd0, m_irq_en, m_ctrl_op, 1'b0};
            else if (addr_i == 4'hD)
                rd = {26'd0, m_to, m_err, m_irq, core_ready_i, m_done, m_busy};
            m_rdata = rd;
        end
        if (wr_en_i && addr_i < 4'h8) begin
            if (!idle) m_err = 1;
            else if (addr_i < 4'h4) m_key[127 - 32*w -: 32] = wdata_i;
            else m_data[127 - 32*w -: 32] = wdata_i;
        end else if (wr_en_i && addr_i == 4'hC) begin
            m_ctrl_op = wdata_i[1];
            m_irq_en  = wdata_i[2];
            if (wdata_i[3]) m_irq = 0;
            if (wdata_i[4]) m_err = 0;
            if (wdata_i[0]) begin
                if (idle) accept = 1;
                else m_err = 1;
            end
        end
        if (fin_ok) begin
            m_result = core_result_i; m_done = 1; m_irq = 1; m_busy = 0;
        end else if (fin_to) begin
            m_to = 1; m_err = 1; m_irq = 1; m_busy = 0;
        end else if (accept) begin
            m_done = 0; m_to = 0; m_busy = 1; m_started = 0; m_cycles = 0;
            m_op = {1'b0, wdata_i[1]};
        end else if (m_busy) begin
            m_cycles++;
            if (go) m_started = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_n_i);
            if (!rst_n_i) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_n_i) begin
                chk("cyc_key",   core_key_o,  m_key);
                chk("cyc_data",  core_data_o, m_data);
                chk("cyc_op",    128'(core_op_o), 128'(m_op));
                chk("cyc_irq",   128'(irq_o), 128'(m_irq && m_irq_en));
                chk("cyc_start", 128'(core_start_o),
                    128'(m_busy && !m_started && core_ready_i && !m_expire_now()));
                chk("cyc_rdata", 128'(rdata_o), 128'(m_rdata));
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        addr_i = a; wdata_i = d; wr_en_i = 1'b1;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        addr_i = a; rd_en_i = 1'b1;
        @(negedge clk_i);
        rd_en_i = 1'b0;
        #1 d = rdata_o;
    endtask

    task automatic load_block(input logic [3:0] base, input logic [127:0] v);
        for (int i = 0; i < 4; i++) bus_wr(base + 4'(i), v[127 - 32*i -: 32]);
    endtask

    // Returns at the falling edge of the cycle in which valid is high.
    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk_i);
        while (core_valid_i !== 1'b1 && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, 128'(n < 60), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] rd;
        int n;
        rst_n_i = 1'b0; addr_i = '0; wr_en_i = 1'b0; rd_en_i = 1'b0; wdata_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_rdata", 128'(rdata_o), 128'(0));
        chk("rst_irq",   128'(irq_o), 128'(0));
        chk("rst_start", 128'(core_start_o), 128'(0));
        chk("rst_key",   core_key_o, 128'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        bus_rd(4'hD, rd);
        chk("rst_status", 128'(rd), 128'(32'h04));

        // 1: FIPS-197 encrypt
        load_block(4'h0, c_key);
        load_block(4'h4, c_pt);
        bus_wr(4'hC, 32'h5);
        wait_valid("t1_wait");
        @(negedge clk_i);
        bus_rd(4'h8, rd); chk("t1_res0", 128'(rd), 128'(32'h69c4e0d8));
        bus_rd(4'h9, rd); chk("t1_res1", 128'(rd), 128'(32'h6a7b0430));
        bus_rd(4'hA, rd); chk("t1_res2", 128'(rd), 128'(32'hd8cdb780));
        bus_rd(4'hB, rd); chk("t1_res3", 128'(rd), 128'(32'h70b4c55a));
        bus_rd(4'hD, rd); chk("t1_status", 128'(rd), 128'(32'h0E));
        chk("t1_irq", 128'(irq_o), 128'(1));
        chk("t1_starts", 128'(n_starts), 128'(1));

        // 2: decrypt round trip
        load_block(4'h4, c_ct);
        bus_wr(4'hC, 32'h3);
        @(negedge clk_i);
        #1 chk("t2_op_busy", 128'(core_op_o), 128'(2'b01));
        wait_valid("t2_wait");
        @(negedge clk_i);
        bus_rd(4'h8, rd); chk("t2_res0", 128'(rd), 128'(32'h00112233));
        bus_rd(4'hB, rd); chk("t2_res3", 128'(rd), 128'(32'hccddeeff));

        // 3: busy rejection, then error clear
        bus_wr(4'hC, 32'h1);
        bus_wr(4'h0, 32'hFFFF_FFFF);
        bus_wr(4'hC, 32'h1);
        #1 chk("t3_key_kept", core_key_o, c_key);
        wait_valid("t3_wait");
        @(negedge clk_i);
        chk("t3_starts", 128'(n_starts), 128'(3));
        bus_rd(4'hD, rd); chk("t3_status_err", 128'(rd), 128'(32'h1E));
        bus_wr(4'hC, 32'h10);
        bus_rd(4'hD, rd); chk("t3_status_clr", 128'(rd), 128'(32'h0E));

        // 4: watchdog timeout with a hung core
        stub_hang = 1'b1;
        bus_wr(4'hC, 32'h8);
        bus_wr(4'hC, 32'h5);
        n = 0;
        while (irq_o !== 1'b1 && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk("t4_cycles", 128'(n), 128'(20));
        bus_rd(4'hD, rd); chk("t4_status", 128'(rd), 128'(32'h3C));
        bus_rd(4'h8, rd); chk("t4_res_kept", 128'(rd), 128'(32'h69c5e2db));
        stub_hang = 1'b0;
        bus_wr(4'hC, 32'h18);

        // 5: launch wait, then reset mid-BUSY
        ready_block = 1'b1;
        bus_wr(4'hC, 32'h1);
        for (int k = 0; k < 5; k++) begin
            #1 chk("t5_no_start", 128'(core_start_o), 128'(0));
            @(negedge clk_i);
        end
        ready_block = 1'b0;
        #1 chk("t5_start_on_ready", 128'(core_start_o), 128'(1));
        @(negedge clk_i);
        #1 chk("t5_start_one", 128'(core_start_o), 128'(0));
        chk("t5_starts", 128'(n_starts), 128'(5));
        @(negedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        chk("t5_rst_rdata", 128'(rdata_o), 128'(0));
        chk("t5_rst_irq",   128'(irq_o), 128'(0));
        chk("t5_rst_start", 128'(core_start_o), 128'(0));
        chk("t5_rst_op",    128'(core_op_o), 128'(0));
        chk("t5_rst_key",   core_key_o, 128'(0));
        chk("t5_rst_data",  core_data_o, 128'(0));
        ready_block = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        bus_rd(4'hD, rd); chk("t5_status", 128'(rd), 128'(32'h00));
        ready_block = 1'b0;

        // 6: irq clear colliding with completion
        load_block(4'h0, c_key);
        load_block(4'h4, c_pt);
        bus_wr(4'hC, 32'h5);
        wait_valid("t6_wait");
        bus_wr(4'hC, 32'h8);
        bus_wr(4'hC, 32'h4);
        #1 chk("t6_irq", 128'(irq_o), 128'(1));
        bus_rd(4'hD, rd); chk("t6_status", 128'(rd), 128'(32'h0E));
        bus_rd(4'h8, rd); chk("t6_res0", 128'(rd), 128'(32'h69c4e0d8));

        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
